// File: rtl/motor_arb_if.sv
// Motor arbiter bus: requests and speed commands from Tracking and Uturn,
// ownership, wheel drive outputs and debug taps.
// Request/grant semantics: a request is a level held for as long as the
// requester wants the motors; the grant is a registered level that rises
// the cycle after the request is sampled and falls on release, preemption
// or estop. Only the current owner's speed commands reach the wheels.
interface motor_arb_if;
    logic       trk_req;
    logic [7:0] trk_left;
    logic [7:0] trk_right;
    logic       ut_req;
    logic [7:0] ut_left;
    logic [7:0] ut_right;
    logic       estop;
    logic       trk_grant;
    logic       ut_grant;
    logic       pwm_l;
    logic       pwm_r;
    logic       dir_l;
    logic       dir_r;
    logic       braking;
    logic [1:0] dbg_state;
    logic [6:0] dbg_m_l;
    logic [6:0] dbg_m_r;

    modport master (
        output trk_req, trk_left, trk_right, ut_req, ut_left, ut_right, estop,
        input  trk_grant, ut_grant, pwm_l, pwm_r, dir_l, dir_r, braking,
        input  dbg_state, dbg_m_l, dbg_m_r
    );

    modport slave (
        input  trk_req, trk_left, trk_right, ut_req, ut_left, ut_right, estop,
        output trk_grant, ut_grant, pwm_l, pwm_r, dir_l, dir_r, braking,
        output dbg_state, dbg_m_l, dbg_m_r
    );
endinterface

// File: rtl/motor_arb.sv
// Motor ownership arbiter between Tracking and Uturn with dead-time braking,
// ramped signed speed commands and 127-step PWM generation per wheel.
module motor_arb #(
    parameter int DEAD_CYCLES = 1000,
    parameter int RAMP_DIV    = 256
) (
    input  logic        clk,
    input  logic        rst,
    motor_arb_if.slave  bus
);
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_TRK = 2'd1,
        OWN_UT  = 2'd2,
        BRAKE   = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [DW-1:0] dead_cnt;
    logic [RW-1:0] ramp_cnt;
    logic [6:0]    pwm_cnt;
    logic [6:0]    m_l, m_r;
    logic          dir_l, dir_r;
    logic          ramp_tick, dead_done;
    logic          owned_now, owned_next;
    logic [7:0]    cmd_l, cmd_r;
    logic [7:0]    step_l, step_r;

    // Saturated magnitude of a signed command; -128 clips to 127.
    function automatic logic [6:0] mag_of(input logic [7:0] c);
        if (!c[7])
            return c[6:0];
        else if (c == 8'h80)
            return 7'd127;
        else
            return ~c[6:0] + 7'd1;
    endfunction

    // One ramp step: reversal first ramps to zero, flips at zero, then climbs.
    function automatic logic [7:0] ramp_step(input logic [6:0] m, input logic dir,
                                             input logic [7:0] cmd);
        logic [6:0] tm;
        logic       td;
        logic [6:0] m_n;
        logic       d_n;
        tm  = mag_of(cmd);
        td  = (cmd == 8'd0) ? dir : ~cmd[7];
        m_n = m;
        d_n = dir;
        if (td != dir) begin
            if (m != 7'd0) m_n = m - 7'd1;
            else           d_n = td;
        end else if (m < tm) begin
            m_n = m + 7'd1;
        end else if (m > tm) begin
            m_n = m - 7'd1;
        end
        return {d_n, m_n};
    endfunction

    assign ramp_tick  = (ramp_cnt == RW'(RAMP_DIV - 1));
    assign dead_done  = (dead_cnt == DW'(DEAD_CYCLES - 1)) && !bus.estop;
    assign owned_now  = (state == OWN_TRK) || (state == OWN_UT);
    assign owned_next = (next_state == OWN_TRK) || (next_state == OWN_UT);
    assign cmd_l      = (state == OWN_UT) ? bus.ut_left  : bus.trk_left;
    assign cmd_r      = (state == OWN_UT) ? bus.ut_right : bus.trk_right;
    assign step_l     = ramp_step(m_l, dir_l, cmd_l);
    assign step_r     = ramp_step(m_r, dir_r, cmd_r);

    // Next-state arbitration; Uturn wins ties and preempts Tracking.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.ut_req)       next_state = OWN_UT;
                else if (bus.trk_req) next_state = OWN_TRK;
            end
            OWN_TRK: begin
                if (!bus.trk_req || bus.ut_req || bus.estop) next_state = BRAKE;
            end
            OWN_UT: begin
                if (!bus.ut_req || bus.estop) next_state = BRAKE;
            end
            BRAKE: begin
                if (dead_done) begin
                    if (bus.ut_req)       next_state = OWN_UT;
                    else if (bus.trk_req) next_state = OWN_TRK;
                    else                  next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register plus grant/braking flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.trk_grant <= 1'b0;
            bus.ut_grant  <= 1'b0;
            bus.braking   <= 1'b0;
        end else begin
            state         <= next_state;
            bus.trk_grant <= (next_state == OWN_TRK);
            bus.ut_grant  <= (next_state == OWN_UT);
            bus.braking   <= (next_state == BRAKE);
        end
    end

    // Dead-time counter: runs only in BRAKE, pinned at zero while estop is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dead_cnt <= '0;
        else if (state != BRAKE || bus.estop || dead_done)
            dead_cnt <= '0;
        else
            dead_cnt <= dead_cnt + DW'(1);
    end

    // Free-running ramp divider and 0..126 PWM carrier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_cnt <= '0;
            pwm_cnt  <= 7'd0;
        end else begin
            ramp_cnt <= ramp_tick ? '0 : ramp_cnt + RW'(1);
            pwm_cnt  <= (pwm_cnt == 7'd126) ? 7'd0 : pwm_cnt + 7'd1;
        end
    end

    // Wheel magnitude/direction: zeroed on losing ownership, ramped while owned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_l   <= 7'd0;
            m_r   <= 7'd0;
            dir_l <= 1'b1;
            dir_r <= 1'b1;
        end else if (!owned_next) begin
            m_l <= 7'd0;
            m_r <= 7'd0;
        end else if (ramp_tick && owned_now) begin
            {dir_l, m_l} <= step_l;
            {dir_r, m_r} <= step_r;
        end
    end

    assign bus.pwm_l     = (pwm_cnt < m_l);
    assign bus.pwm_r     = (pwm_cnt < m_r);
    assign bus.dir_l     = dir_l;
    assign bus.dir_r     = dir_r;
    assign bus.dbg_state = state;
    assign bus.dbg_m_l   = m_l;
    assign bus.dbg_m_r   = m_r;
endmodule

// File: tb/tb_motor_arb.sv
// Directed scoreboard bench for motor_arb: the driver pushes expected
// observations, a negedge monitor pops and compares them and also watches
// that no direction flip happens with a non-zero magnitude.
module tb_motor_arb;
    localparam int D = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst;

    motor_arb_if bus();

    motor_arb #(.DEAD_CYCLES(D), .RAMP_DIV(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    logic [126:0] hist_l = '0;
    logic [126:0] hist_r = '0;
    logic         prev_dir_l = 1'b1;
    logic         prev_dir_r = 1'b1;
    logic         prev_rst = 1'b1;
    logic [6:0]   prev_m_l = 7'd0;
    logic [6:0]   prev_m_r = 7'd0;

    localparam int K_FLAGS = 0;
    localparam int K_DUTY  = 1;
    localparam int K_MAG   = 2;
    localparam int K_PWM   = 3;

    function automatic logic [31:0] fl(input logic [1:0] st, input logic tg, input logic ug,
                                       input logic br, input logic dl, input logic dr);
        return {25'd0, st, tg, ug, br, dl, dr};
    endfunction

    function automatic logic [31:0] pair(input logic [7:0] a, input logic [7:0] b);
        return {16'd0, a, b};
    endfunction

    task automatic expect_val(input int kind, input string name, input logic [31:0] v);
        exp_q.push_back(v);
        kind_q.push_back(kind);
        name_q.push_back(name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] obs;
        logic [31:0] e;
        int          k;
        string       nm;
        hist_l = {hist_l[125:0], bus.pwm_l};
        hist_r = {hist_r[125:0], bus.pwm_r};
        if (!rst && !prev_rst) begin
            if (bus.dir_l !== prev_dir_l) begin
                total++;
                if (prev_m_l != 7'd0 || bus.dbg_m_l != 7'd0) begin
                    bad++;
                    $display("FAIL dir_l_flip: m_l before=%0d after=%0d required 0", prev_m_l, bus.dbg_m_l);
                end
            end
            if (bus.dir_r !== prev_dir_r) begin
                total++;
                if (prev_m_r != 7'd0 || bus.dbg_m_r != 7'd0) begin
                    bad++;
                    $display("FAIL dir_r_flip: m_r before=%0d after=%0d required 0", prev_m_r, bus.dbg_m_r);
                end
            end
        end
        prev_dir_l = bus.dir_l;
        prev_dir_r = bus.dir_r;
        prev_m_l   = bus.dbg_m_l;
        prev_m_r   = bus.dbg_m_r;
        prev_rst   = rst;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            k  = kind_q.pop_front();
            nm = name_q.pop_front();
            case (k)
                K_FLAGS: obs = fl(bus.dbg_state, bus.trk_grant, bus.ut_grant, bus.braking, bus.dir_l, bus.dir_r);
                K_DUTY:  obs = pair(8'($countones(hist_l)), 8'($countones(hist_r)));
                K_MAG:   obs = pair({1'b0, bus.dbg_m_l}, {1'b0, bus.dbg_m_r});
                default: obs = {30'd0, bus.pwm_l, bus.pwm_r};
            endcase
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", nm, obs, e);
            end
        end
    end

    // Driver: directed scenarios
    initial begin
        rst = 1'b1;
        bus.trk_req = 1'b0; bus.trk_left = 8'd0; bus.trk_right = 8'd0;
        bus.ut_req  = 1'b0; bus.ut_left  = 8'd0; bus.ut_right  = 8'd0;
        bus.estop   = 1'b0;
        tick(2);
        expect_val(K_FLAGS, "reset_flags", fl(2'd0, 0, 0, 0, 1, 1));
        expect_val(K_MAG,   "reset_mag",   pair(8'd0, 8'd0));
        expect_val(K_PWM,   "reset_pwm",   32'd0);
        rst = 1'b0;
        tick(1);

        // Tracking alone at +64 on both wheels
        bus.trk_req = 1'b1; bus.trk_left = 8'd64; bus.trk_right = 8'd64;
        expect_val(K_FLAGS, "trk_before_edge", fl(2'd0, 0, 0, 0, 1, 1));
        tick(1);
        expect_val(K_FLAGS, "trk_grant", fl(2'd1, 1, 0, 0, 1, 1));
        tick(64 * R + 2 * R + 130);
        expect_val(K_MAG,  "trk_mag64",  pair(8'd64, 8'd64));
        expect_val(K_DUTY, "trk_duty64", pair(8'd64, 8'd64));

        // Uturn preempts Tracking: brake for D cycles, then Uturn owns
        bus.ut_req = 1'b1; bus.ut_left = 8'd10; bus.ut_right = 8'hFB;
        tick(1);
        expect_val(K_FLAGS, "preempt_brake", fl(2'd3, 0, 0, 1, 1, 1));
        expect_val(K_MAG,   "preempt_mag0",  pair(8'd0, 8'd0));
        expect_val(K_PWM,   "preempt_pwm0",  32'd0);
        tick(D - 1);
        expect_val(K_FLAGS, "brake_last", fl(2'd3, 0, 0, 1, 1, 1));
        expect_val(K_PWM,   "brake_last_pwm", 32'd0);
        tick(1);
        expect_val(K_FLAGS, "ut_grant", fl(2'd2, 0, 1, 0, 1, 1));
        tick(15 * R);
        expect_val(K_MAG,   "ut_mag_10_5", pair(8'd10, 8'd5));
        expect_val(K_FLAGS, "ut_dir_r_rev", fl(2'd2, 0, 1, 0, 1, 0));

        // Left reversal +10 -> -10
        bus.ut_left = 8'hF6;
        tick(25 * R);
        expect_val(K_MAG,   "rev_mag",   pair(8'd10, 8'd5));
        expect_val(K_FLAGS, "rev_flags", fl(2'd2, 0, 1, 0, 0, 0));

        // estop during Uturn ownership
        bus.estop = 1'b1;
        tick(1);
        expect_val(K_FLAGS, "estop_brake", fl(2'd3, 0, 0, 1, 0, 0));
        tick(39);
        expect_val(K_FLAGS, "estop_hold", fl(2'd3, 0, 0, 1, 0, 0));
        bus.estop = 1'b0;
        tick(D - 1);
        expect_val(K_FLAGS, "estop_dead_last", fl(2'd3, 0, 0, 1, 0, 0));
        tick(1);
        expect_val(K_FLAGS, "estop_regrant", fl(2'd2, 0, 1, 0, 0, 0));

        // Reset in the middle of BRAKE
        bus.ut_req = 1'b0;
        tick(1);
        expect_val(K_FLAGS, "release_brake", fl(2'd3, 0, 0, 1, 0, 0));
        tick(3);
        rst = 1'b1; bus.trk_req = 1'b0;
        expect_val(K_FLAGS, "rst_mid_brake", fl(2'd0, 0, 0, 0, 1, 1));
        expect_val(K_MAG,   "rst_mid_brake_mag", pair(8'd0, 8'd0));
        tick(2);
        rst = 1'b0;
        tick(D + 2);
        expect_val(K_FLAGS, "idle_after_rst", fl(2'd0, 0, 0, 0, 1, 1));

        // Simultaneous requests, full-scale commands
        bus.trk_req = 1'b1; bus.ut_req = 1'b1; bus.ut_left = 8'h7F; bus.ut_right = 8'h80;
        tick(1);
        expect_val(K_FLAGS, "tie_ut_wins", fl(2'd2, 0, 1, 0, 1, 1));
        tick(130 * R + 130);
        expect_val(K_MAG,   "full_mag",   pair(8'd127, 8'd127));
        expect_val(K_FLAGS, "full_flags", fl(2'd2, 0, 1, 0, 1, 0));
        expect_val(K_DUTY,  "full_duty",  pair(8'd127, 8'd127));
        expect_val(K_PWM,   "full_pwm",   32'd3);

        // Reset in the middle of a ramp
        bus.ut_left = 8'd20;
        tick(10 * R);
        rst = 1'b1;
        expect_val(K_FLAGS, "rst_mid_ramp", fl(2'd0, 0, 0, 0, 1, 1));
        expect_val(K_MAG,   "rst_mid_ramp_mag", pair(8'd0, 8'd0));
        expect_val(K_PWM,   "rst_mid_ramp_pwm", 32'd0);
        tick(1);
        rst = 1'b0; bus.ut_req = 1'b0; bus.trk_req = 1'b0;
        tick(1);

        // Non-owner commands ignored; estop from Tracking ownership
        bus.trk_req = 1'b1; bus.trk_left = 8'd3; bus.trk_right = 8'hFD;
        bus.ut_left = 8'd100; bus.ut_right = 8'd100;
        tick(1);
        expect_val(K_FLAGS, "trk2_grant", fl(2'd1, 1, 0, 0, 1, 1));
        tick(12 * R);
        expect_val(K_MAG,   "trk2_mag",   pair(8'd3, 8'd3));
        expect_val(K_FLAGS, "trk2_flags", fl(2'd1, 1, 0, 0, 1, 0));
        bus.estop = 1'b1;
        tick(1);
        expect_val(K_FLAGS, "trk_estop", fl(2'd3, 0, 0, 1, 1, 0));
        expect_val(K_MAG,   "trk_estop_mag", pair(8'd0, 8'd0));
        bus.estop = 1'b0; bus.trk_req = 1'b0;
        tick(D - 1);
        expect_val(K_FLAGS, "trk_estop_dead", fl(2'd3, 0, 0, 1, 1, 0));
        tick(1);
        expect_val(K_FLAGS, "brake_to_idle", fl(2'd0, 0, 0, 0, 1, 0));

        // Tracking release path
        bus.trk_req = 1'b1;
        tick(1);
        expect_val(K_FLAGS, "trk3_grant", fl(2'd1, 1, 0, 0, 1, 0));
        bus.trk_req = 1'b0;
        tick(1);
        expect_val(K_FLAGS, "trk3_release", fl(2'd3, 0, 0, 1, 1, 0));
        tick(D);
        expect_val(K_FLAGS, "trk3_idle", fl(2'd0, 0, 0, 0, 1, 0));

        tick(2);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
